// File: rtl/rgmii_tx_framer_if.sv
// rgmii_tx_framer_if: byte-stream handshake into the RGMII transmit framer
//   s_data  : payload byte
//   s_valid : s_data valid
//   s_last  : final byte of the frame
//   s_ready : byte accepted when s_valid & s_ready
`timescale 1ns/1ps
interface rgmii_tx_framer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    modport master (output s_data, s_valid, s_last, input s_ready);
    modport slave (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/rgmii_tx_framer.sv
// rgmii_tx_framer: Ethernet framer feeding RGMII ODDR pairs (preamble, SFD, pad, CRC-32 FCS, IFG)
//   tx_clk     : byte clock
//   tx_rst_n   : synchronous active-low reset
//   s          : byte stream slave (s_data/s_valid/s_last/s_ready)
//   txd_rise   : low nibble of the output byte, txd_fall: high nibble
//   ctl_rise   : TX_EN, ctl_fall: TX_EN ^ TX_ER
//   busy       : framer was outside IDLE when the current output byte was decided
//   frame_done : pulse with the last byte of a completed frame
//   underrun   : pulse with the error symbol of an aborted frame
//   frame_cnt  : completed frames, saturating
`timescale 1ns/1ps
module rgmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter bit PAD_EN       = 1'b1,
    parameter bit FCS_EN       = 1'b1,
    parameter int IFG_BYTES    = 12
) (
    input  logic             tx_clk,
    input  logic             tx_rst_n,
    rgmii_tx_framer_if.slave s,
    output logic [3:0]       txd_rise,
    output logic [3:0]       txd_fall,
    output logic             ctl_rise,
    output logic             ctl_fall,
    output logic             busy,
    output logic             frame_done,
    output logic             underrun,
    output logic [15:0]      frame_cnt
);
    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DRAIN} state_t;

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);
    localparam logic [8:0] MIN_LEN  = 9'(MIN_FRAME);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [8:0]  byte_cnt_inc;
    logic [7:0]  byte_d, txd_q;
    logic        en_d, er_d, done_d, underrun_d;
    logic        ctl_rise_q, ctl_fall_q, busy_q, frame_done_q, underrun_q;
    logic [15:0] frame_cnt_q;

    // Reflected CRC-32 update, one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    // 9 bits so the comparison against MIN_FRAME cannot wrap at 255.
    assign byte_cnt_inc = {1'b0, byte_cnt_q} + 9'd1;
    assign s.s_ready    = (state_q == DATA) || (state_q == DRAIN);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        byte_d     = 8'h00;
        en_d       = 1'b0;
        er_d       = 1'b0;
        done_d     = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            IDLE: if (s.s_valid) state_d = PRE;
            PRE: begin
                byte_d = 8'h55;
                en_d   = 1'b1;
                cnt_d  = cnt_q + 8'd1;
                if (cnt_q == PRE_LAST) begin
                    state_d = SFD;
                    cnt_d   = '0;
                end
            end
            SFD: begin
                byte_d  = 8'hD5;
                en_d    = 1'b1;
                state_d = DATA;
            end
            DATA: begin
                en_d = 1'b1;
                if (s.s_valid) begin
                    byte_d     = s.s_data;
                    crc_d      = crc_byte(crc_q, s.s_data);
                    byte_cnt_d = byte_cnt_inc[8] ? 8'hFF : byte_cnt_inc[7:0];
                    if (s.s_last) begin
                        if (PAD_EN && byte_cnt_inc < MIN_LEN) state_d = PAD;
                        else if (FCS_EN) state_d = FCS;
                        else begin
                            state_d = IFG;
                            done_d  = 1'b1;
                        end
                    end
                end else begin
                    // Starved mid-frame: one error symbol, then swallow the rest of the frame.
                    er_d       = 1'b1;
                    underrun_d = 1'b1;
                    state_d    = DRAIN;
                end
            end
            PAD: begin
                en_d       = 1'b1;
                crc_d      = crc_byte(crc_q, 8'h00);
                byte_cnt_d = byte_cnt_inc[8] ? 8'hFF : byte_cnt_inc[7:0];
                if (byte_cnt_inc >= MIN_LEN) begin
                    state_d = FCS_EN ? FCS : IFG;
                    done_d  = !FCS_EN;
                end
            end
            FCS: begin
                en_d   = 1'b1;
                byte_d = ~crc_q[{cnt_q[1:0], 3'b000} +: 8];
                cnt_d  = cnt_q + 8'd1;
                if (cnt_q[1:0] == 2'd3) begin
                    state_d = IFG;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            IFG: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == IFG_LAST) begin
                    // A pending frame skips IDLE so the gap is exactly IFG_BYTES.
                    state_d = s.s_valid ? PRE : IDLE;
                    cnt_d   = '0;
                end
            end
            DRAIN: if (s.s_valid && s.s_last) state_d = IFG;
            default: state_d = IDLE;
        endcase
        if (state_d == PRE && state_q != PRE) begin
            cnt_d      = '0;
            byte_cnt_d = '0;
            crc_d      = '1;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (!tx_rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            byte_cnt_q   <= '0;
            crc_q        <= '1;
            txd_q        <= '0;
            ctl_rise_q   <= 1'b0;
            ctl_fall_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            crc_q        <= crc_d;
            txd_q        <= byte_d;
            ctl_rise_q   <= en_d;
            ctl_fall_q   <= en_d ^ er_d;
            busy_q       <= state_q != IDLE;
            frame_done_q <= done_d;
            underrun_q   <= underrun_d;
            if (done_d && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign txd_rise   = txd_q[3:0];
    assign txd_fall   = txd_q[7:4];
    assign ctl_rise   = ctl_rise_q;
    assign ctl_fall   = ctl_fall_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;
    assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_rgmii_tx_framer.sv
// tb_rgmii_tx_framer: three framer configurations checked against a wire-symbol model
`timescale 1ns/1ps
module tb_rgmii_tx_framer;
    typedef struct packed {
        logic [7:0] b;
        logic       en;
        logic       er;
        logic       done;
        logic       und;
    } sym_t;
    typedef logic [7:0] bytes_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic chk_en = 1'b0;
    always #4 clk = ~clk;

    logic [7:0]  sd[3];
    logic        sv[3], sl[3], rdy[3];
    logic [3:0]  tr[3], tf[3];
    logic        cr[3], cf[3], bz[3], fd[3], un[3];
    logic [15:0] fc[3];

    sym_t expq[3][$];
    bit   synced[3];
    int   exp_cnt[3];
    int   checks = 0;
    int   errors = 0;

    // Instance 0: defaults; 1: no padding; 2: no padding, no FCS.
    for (genvar k = 0; k < 3; k++) begin : g
        rgmii_tx_framer_if bus();
        assign bus.s_data  = sd[k];
        assign bus.s_valid = sv[k];
        assign bus.s_last  = sl[k];
        assign rdy[k]      = bus.s_ready;
        rgmii_tx_framer #(.PAD_EN(k == 0), .FCS_EN(k != 2)) u_dut (
            .tx_clk(clk), .tx_rst_n(rst_n), .s(bus),
            .txd_rise(tr[k]), .txd_fall(tf[k]), .ctl_rise(cr[k]), .ctl_fall(cf[k]),
            .busy(bz[k]), .frame_done(fd[k]), .underrun(un[k]), .frame_cnt(fc[k])
        );
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, got, want);
        end
    endtask

    function automatic logic [31:0] crc32(input logic [7:0] d[$]);
        logic [31:0] c = '1;
        logic fb;
        foreach (d[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    // Wire symbols of one frame from its first preamble byte to the end of the gap.
    function automatic void build(input int k, input logic [7:0] d[$], input int abort_at, output sym_t s[$]);
        logic [7:0] body[$];
        logic [31:0] c;
        s = {};
        for (int i = 0; i < 7; i++) s.push_back(sym_t'({8'h55, 4'b1000}));
        s.push_back(sym_t'({8'hD5, 4'b1000}));
        if (abort_at >= 0) begin
            for (int i = 0; i < abort_at; i++) s.push_back(sym_t'({d[i], 4'b1000}));
            s.push_back(sym_t'({8'h00, 4'b1101}));
            for (int i = abort_at; i < d.size(); i++) s.push_back(sym_t'({8'h00, 4'b0000}));
        end else begin
            body = d;
            if (k == 0) while (body.size() < 60) body.push_back(8'h00);
            c = crc32(body);
            foreach (body[i]) s.push_back(sym_t'({body[i], 2'b10, k == 2 && i == body.size() - 1, 1'b0}));
            if (k != 2) for (int j = 0; j < 4; j++) s.push_back(sym_t'({c[8*j +: 8], 2'b10, j == 3, 1'b0}));
        end
        for (int i = 0; i < 12; i++) s.push_back(sym_t'({8'h00, 4'b0000}));
    endfunction

    task automatic send(input int k, input logic [7:0] d[$], input int abort_at, output int waits);
        sym_t s[$];
        int i = 0;
        int cyc = 0;
        bit acc;
        build(k, d, abort_at, s);
        foreach (s[j]) expq[k].push_back(s[j]);
        waits = 0;
        sv[k] = 1'b1;
        sd[k] = d[0];
        sl[k] = d.size() == 1;
        while (i < d.size() && cyc < 3000) begin
            @(negedge clk);
            acc = sv[k] && rdy[k];
            if (!acc && i == 0) waits++;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) i++;
            if (i < d.size()) begin
                sd[k] = d[i];
                sl[k] = i == d.size() - 1;
                sv[k] = !(acc && i == abort_at);
            end
        end
        sv[k] = 1'b0;
        sl[k] = 1'b0;
        chk("send_done", i, d.size());
    endtask

    task automatic drain();
        int n = 0;
        while (expq[0].size() + expq[1].size() + expq[2].size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain", n < 500, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            sym_t e;
            logic [12:0] want;
            if (!rst_n) begin
                expq[k].delete();
                synced[k] = 1'b0;
                exp_cnt[k] = 0;
            end else if (chk_en) begin
                want = '0;
                if (!synced[k] && cr[k] && expq[k].size() > 0) synced[k] = 1'b1;
                if (synced[k]) begin
                    e = expq[k].pop_front();
                    want = {e.b[3:0], e.b[7:4], e.en, e.en ^ e.er, e.done, e.und, 1'b1};
                    if (e.done) exp_cnt[k]++;
                    if (expq[k].size() == 0) synced[k] = 1'b0;
                end
                chk($sformatf("out%0d", k), {tr[k], tf[k], cr[k], cf[k], fd[k], un[k], bz[k]}, want);
                chk($sformatf("frame_cnt%0d", k), fc[k], exp_cnt[k]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        sym_t s[$];
        bytes_t q, q2;
        int w, w2, n;
        for (int k = 0; k < 3; k++) begin
            sv[k] = 1'b0;
            sl[k] = 1'b0;
            sd[k] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_out", {tr[k], tf[k], cr[k], cf[k], fd[k], un[k], bz[k]}, 0);
            chk("reset_cnt", fc[k], 0);
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        q = {};
        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
        chk("crc_ref", crc32(q), 32'hCBF43926);

        // "123456789" without padding: FCS 26 39 F4 CB.
        build(1, q, -1, s);
        chk("a_len", s.size(), 33);
        chk("a_fcs0", s[17], {8'h26, 4'b1000});
        chk("a_fcs3", s[20], {8'hCB, 4'b1010});
        send(1, q, -1, w);
        chk("a_wait", w, 9);
        drain();
        chk("a_cnt", fc[1], 1);

        // 14 bytes of 0xAA padded to 60.
        q = {};
        for (int i = 0; i < 14; i++) q.push_back(8'hAA);
        build(0, q, -1, s);
        chk("b_len", s.size(), 84);
        chk("b_lastdata", s[21], {8'hAA, 4'b1000});
        chk("b_firstpad", s[22], {8'h00, 4'b1000});
        chk("b_lastpad", s[67], {8'h00, 4'b1000});
        chk("b_done", s[71].done, 1);
        send(0, q, -1, w);
        chk("b_wait", w, 9);
        drain();
        chk("b_cnt", fc[0], 1);

        // Starve after 5 of 20 bytes.
        q = {};
        for (int i = 1; i <= 20; i++) q.push_back(8'(i));
        build(0, q, 5, s);
        chk("u_len", s.size(), 41);
        chk("u_err", s[13], {8'h00, 4'b1101});
        chk("u_drain", s[14], {8'h00, 4'b0000});
        send(0, q, 5, w);
        chk("u_wait", w, 9);
        drain();
        chk("u_cnt", fc[0], 1);

        // Back-to-back 60-byte frames with s_valid held.
        q = {};
        q2 = {};
        for (int i = 0; i < 60; i++) begin
            q.push_back(8'(i * 3));
            q2.push_back(8'hFF - 8'(i));
        end
        send(0, q, -1, w);
        send(0, q2, -1, w2);
        chk("bb_wait1", w, 9);
        chk("bb_wait2", w2, 24);
        drain();
        chk("bb_cnt", fc[0], 3);

        // Single byte, no pad, no FCS.
        q = {8'h5A};
        build(2, q, -1, s);
        chk("r_len", s.size(), 21);
        chk("r_byte", s[8], {8'h5A, 4'b1010});
        chk("r_idle", s[9], {8'h00, 4'b0000});
        send(2, q, -1, w);
        chk("r_wait", w, 9);
        drain();
        chk("r_cnt", fc[2], 1);

        // One-cycle reset mid-DATA, then a clean frame.
        chk_en = 1'b0;
        sv[0] = 1'b1;
        sd[0] = 8'h11;
        n = 0;
        for (int c = 0; c < 200 && n < 3; c++) begin
            @(negedge clk);
            if (rdy[0]) n++;
            @(posedge clk);
            #1;
        end
        chk("rst_accepts", n, 3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sv[0] = 1'b0;
        @(negedge clk);
        chk("rst_mid_out", {tr[0], tf[0], cr[0], cf[0], fd[0], un[0], bz[0]}, 0);
        chk("rst_mid_cnt", {fc[0], fc[1]}, 0);
        chk("rst_mid_cnt2", fc[2], 0);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        q = {};
        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
        send(0, q, -1, w);
        chk("x_wait", w, 9);
        drain();
        chk("x_cnt", fc[0], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rgmii_tx_framer.md
Name: rgmii_tx_framer

Overview:
- Parametrised successor to the bare RGMII nibble transmitter.
- Accepts a byte stream with a valid/ready/last handshake. Inserts preamble and SFD, pads short frames, appends the Ethernet FCS (CRC-32) and enforces the inter-frame gap.
- Emits registered rise/fall nibble and control pairs for the downstream ODDR primitives, which drive the RGMII pins. No clock-muxed outputs.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes before the SFD (1..15)
MIN_FRAME, 60, minimum payload+header bytes before FCS; shorter frames are zero-padded (0..255)
PAD_EN, 1, 1 = pad short frames to MIN_FRAME; 0 = no padding
FCS_EN, 1, 1 = append 4-byte CRC-32; 0 = no FCS
IFG_BYTES, 12, idle byte times after each frame, including aborted frames (1..255)

Ports:
tx_clk  in  1  byte clock (125 MHz at 1G)
tx_rst_n  in  1  synchronous active-low reset
s_data  in  8  payload byte
s_valid  in  1  s_data valid
s_last  in  1  final byte of frame
s_ready  out  1  byte accepted when s_valid & s_ready
txd_rise  out  4  nibble for the rising edge, {byte[3:0]}
txd_fall  out  4  nibble for the falling edge, {byte[7:4]}
ctl_rise  out  1  TX_EN
ctl_fall  out  1  TX_EN xor TX_ER
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse on the last FCS/data byte output
underrun  out  1  one-cycle pulse when a frame is aborted
frame_cnt  out  16  completed-frame count, saturating at 0xFFFF

Behaviour:
- Reset (tx_rst_n=0 at posedge): state=IDLE; all outputs 0; CRC=0xFFFFFFFF; counters 0.
  - Reset mid-frame truncates output immediately with no error symbol.
  - After reset the IFG is treated as already satisfied.
- All outputs are registered. The byte decided in cycle N appears on txd/ctl in cycle N+1.
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DRAIN.
- IDLE: en=0, data 0x00. s_valid=1 -> PRE. s_ready=0 (the first byte stays pending).
- PRE: output 0x55 with en=1 for PREAMBLE_LEN cycles -> SFD.
- SFD: output 0xD5, en=1, one cycle -> DATA. s_ready=1 from the DATA cycle on.
- DATA:
  - s_ready=1. Each accepted byte is output with en=1, fed into CRC and counted in byte_cnt (8-bit, saturating).
  - On an accepted s_last:
    - PAD_EN and byte_cnt+1 < MIN_FRAME -> PAD.
    - else FCS_EN -> FCS.
    - else -> IFG, with frame_done pulsing with this byte.
- Underrun: in DATA with s_valid=0, output one byte 0x00 with en=1 and er=1 (ctl_rise=1, ctl_fall=0), pulse underrun.
  - Then: if s_last was not yet seen -> DRAIN, else -> IFG.
  - An aborted frame does not increment frame_cnt.
- PAD: output 0x00 (CRC'd) until byte_cnt reaches MIN_FRAME, then -> FCS or IFG per FCS_EN. s_ready=0.
- FCS:
  - Output the 4 bytes of ~CRC, LSB byte first, en=1.
  - frame_done pulses with the 4th byte; -> IFG.
- CRC: reflected CRC-32, polynomial 0x04C11DB7 (reflected 0xEDB88320), init 0xFFFFFFFF. Computed over data+pad only, never over preamble/SFD.
- IFG: en=0 for IFG_BYTES cycles; s_ready=0; -> IDLE.
  - s_valid held high during IFG starts PRE in the cycle after IFG ends.
- DRAIN: s_ready=1, en=0. Discard input until an accepted s_last -> IFG.
- frame_cnt increments in the frame_done cycle; holds at 0xFFFF.
- CRC and byte_cnt reinitialise on each IDLE->PRE transition.
- s_last is honoured only with s_valid & s_ready.

Test Plan:
- PAD_EN=0, FCS_EN=1: send ASCII "123456789" (0x31..0x39) -> wire shows 7×0x55, 0xD5, the 9 bytes, then 0x26 0x39 0xF4 0xCB. Expect txd_rise=0x6, txd_fall=0x2 on the first FCS byte; frame_done on 0xCB; frame_cnt=1.
- Defaults, 14-byte frame of 0xAA -> 46 pad bytes of 0x00 follow (60 data bytes total), then 4 FCS bytes. Then 12 cycles ctl_rise=0 before the next preamble; busy low only after IFG.
- s_valid dropped after 5 of 20 bytes -> one cycle ctl_rise=1/ctl_fall=0, underrun pulse. Remaining 15 bytes are accepted with en=0; IFG of 12 cycles follows; frame_cnt unchanged.
- Back-to-back frames with s_valid held high -> gap between last FCS byte and next 0x55 is exactly IFG_BYTES cycles. s_ready=0 throughout PRE/SFD/IFG.
- tx_rst_n asserted for one cycle mid-DATA -> next cycle all outputs 0, state IDLE. A new frame then restarts the preamble with CRC reinitialised and a correct FCS.
- PAD_EN=0, FCS_EN=0, 1-byte frame 0x5A -> 0x55×7, 0xD5, 0x5A, then en=0. frame_done pulses with the 0x5A byte.
